// File: rtl/calc_seq_responder.sv
// -----------------------------------------------------------------------------
// calc_seq_responder
// Unit-side responder for the calculator start/result protocol. Accepts an
// operation, arbitrates for the shared resource against peer units, runs
// add/sub in one cycle and mul/div bit-serially, then pulses done for one
// cycle with registered result, remainder and sticky error flags.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             request, sampled only in IDLE
//   mode[3:0]         0 add, 1 sub, 2 mul, 3 div, others invalid
//   a, b              operands (a = dividend, b = divisor)
//   peer_working      OR of peer units' working outputs
//   working           this unit owns the shared resource (EXEC/MUL/DIV)
//   busy              high in every state except IDLE
//   done              one-cycle completion pulse
//   result            sum / difference / low product / quotient
//   remainder         division remainder, 0 for other modes
//   div_by_zero       set for mode 3 with b == 0
//   bad_mode          set for mode > 3
// -----------------------------------------------------------------------------
module calc_seq_responder #(
    parameter int unsigned WIDTH     = 64,
    parameter bit          HIGH_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             peer_working,
    output logic             working,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             bad_mode
);

    localparam int unsigned CNT_W    = $clog2(WIDTH + 1);
    localparam logic [3:0]  MODE_ADD = 4'd0;
    localparam logic [3:0]  MODE_SUB = 4'd1;
    localparam logic [3:0]  MODE_MUL = 4'd2;
    localparam logic [3:0]  MODE_DIV = 4'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_PEER,
        S_EXEC,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [3:0]       r_mode;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_acc;      // product accumulator / partial remainder
    logic [WIDTH-1:0] r_sh;       // shifted multiplicand / dividend-to-quotient
    logic [WIDTH-1:0] r_mplier;   // multiplier, consumed LSB first
    logic [CNT_W-1:0] r_cnt;
    logic             r_working;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;
    logic             r_bad_mode;

    // Route an accepted operation to its execution state; errors resolve in EXEC.
    function automatic state_t f_dispatch(input logic [3:0] m, input logic b_zero);
        state_t s;
        s = S_EXEC;
        case (m)
            MODE_MUL: s = S_MUL;
            MODE_DIV: s = b_zero ? S_EXEC : S_DIV;
            default:  s = S_EXEC;
        endcase
        return s;
    endfunction

    // Datapath terms for one iteration.
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;
    logic             w_last;
    state_t           w_dispatch_idle;
    state_t           w_dispatch_wait;

    assign w_sum       = r_opa + r_opb;
    assign w_diff      = r_opa - r_opb;
    assign w_mul_acc   = r_mplier[0] ? (r_acc + r_sh) : r_acc;
    // Restoring step: bring in the next dividend bit, subtract if it fits.
    // When it fits the difference is below b, so the low WIDTH bits suffice.
    assign w_div_shift = {r_acc, r_sh[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    assign w_div_rem   = w_div_ge ? (w_div_shift[WIDTH-1:0] - r_opb)
                                  : w_div_shift[WIDTH-1:0];
    assign w_div_quo   = {r_sh[WIDTH-2:0], w_div_ge};
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

    assign w_dispatch_idle = f_dispatch(mode, (b == '0));
    assign w_dispatch_wait = f_dispatch(r_mode, (r_opb == '0));

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_mode        <= '0;
            r_opa         <= '0;
            r_opb         <= '0;
            r_acc         <= '0;
            r_sh          <= '0;
            r_mplier      <= '0;
            r_cnt         <= '0;
            r_working     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_bad_mode    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode        <= mode;
                        r_opa         <= a;
                        r_opb         <= b;
                        r_acc         <= '0;
                        r_sh          <= a;
                        r_mplier      <= b;
                        r_cnt         <= '0;
                        r_div_by_zero <= 1'b0;
                        r_bad_mode    <= 1'b0;
                        r_busy        <= 1'b1;
                        if (peer_working && !HIGH_PRIO) begin
                            r_state   <= S_WAIT_PEER;
                            r_working <= 1'b0;
                        end else begin
                            r_state   <= w_dispatch_idle;
                            r_working <= 1'b1;
                        end
                    end
                end

                S_WAIT_PEER: begin
                    if (!peer_working) begin
                        r_state   <= w_dispatch_wait;
                        r_working <= 1'b1;
                    end
                end

                S_EXEC: begin
                    case (r_mode)
                        MODE_ADD: begin
                            r_result    <= w_sum;
                            r_remainder <= '0;
                        end
                        MODE_SUB: begin
                            r_result    <= w_diff;
                            r_remainder <= '0;
                        end
                        MODE_DIV: begin
                            // Only a zero divisor reaches EXEC in divide mode.
                            r_result      <= '1;
                            r_remainder   <= r_opa;
                            r_div_by_zero <= 1'b1;
                        end
                        default: begin
                            r_result    <= '0;
                            r_remainder <= '0;
                            r_bad_mode  <= 1'b1;
                        end
                    endcase
                    r_state   <= S_DONE;
                    r_working <= 1'b0;
                    r_done    <= 1'b1;
                end

                S_MUL: begin
                    r_acc    <= w_mul_acc;
                    r_sh     <= r_sh << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result    <= w_mul_acc;
                        r_remainder <= '0;
                        r_state     <= S_DONE;
                        r_working   <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end

                S_DIV: begin
                    r_acc <= w_div_rem;
                    r_sh  <= w_div_quo;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result    <= w_div_quo;
                        r_remainder <= w_div_rem;
                        r_state     <= S_DONE;
                        r_working   <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_working <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign working     = r_working;
    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;
    assign bad_mode    = r_bad_mode;

endmodule
